// File: rtl/vga_frame_engine.sv
// VGA scan-out engine: runtime-parametrised timing, scaled/packed framebuffer fetch,
// test patterns and frame-synchronous mode switching with sync aligned to pixel data.
module vga_frame_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int SCALE_LOG2 = 1,
  parameter int PIX_LOG2   = 1,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [7:0]        rgb,
  output logic              frame_start,
  output logic [1:0]        mode
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] H_SC_MASK = HW'((1 << SCALE_LOG2) - 1);
  localparam logic [VW-1:0] V_SC_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [HW-1:0] PX_MASK   = HW'((1 << PIX_LOG2) - 1);
  localparam logic [ADDR_W-1:0] WPL   = ADDR_W'((H_ACTIVE >> SCALE_LOG2) >> PIX_LOG2);
  localparam logic SYNC_ON            = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    MODE_FB      = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  logic [HW-1:0]     h, sx, sel1;
  logic [VW-1:0]     v, v_inc;
  logic [ADDR_W-1:0] line_base, word_addr;
  logic [1:0]        pending;
  mode_e             cur_mode, mode_now;
  logic              frame_hit, active, first_of_word, fetch;
  logic [2:0]        bar;
  logic [7:0]        pat, pat1;
  logic              de1, hs1, vs1, fb1;
  logic [DATA_W-1:0] word, src, shifted;

  function automatic logic [7:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    bar_colour = 8'hFF;
      3'd1:    bar_colour = 8'hFC;
      3'd2:    bar_colour = 8'h1F;
      3'd3:    bar_colour = 8'h1C;
      3'd4:    bar_colour = 8'hE3;
      3'd5:    bar_colour = 8'hE0;
      3'd6:    bar_colour = 8'h03;
      default: bar_colour = 8'h00;
    endcase
  endfunction

  assign v_inc     = v + 1'b1;
  assign frame_hit = pix_ce && (h == '0) && (v == '0);
  // The pixel that triggers the mode load must already be rendered in the new mode.
  assign mode_now  = frame_hit ? mode_e'(pending) : cur_mode;
  assign active    = (h < H_ACT) && (v < V_ACT);
  assign sx        = h >> SCALE_LOG2;
  assign first_of_word = ((sx & PX_MASK) == '0) && ((h & H_SC_MASK) == '0);
  assign word_addr = line_base + ADDR_W'(sx >> PIX_LOG2);
  assign fetch     = pix_ce && active && (mode_now == MODE_FB) && first_of_word;
  assign mode      = cur_mode;

  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h >= HW'((k * H_ACTIVE + 7) / 8)) bar = bar + 3'd1;
    end
    pat = 8'h00;
    unique case (mode_now)
      MODE_BARS:    pat = bar_colour(bar);
      MODE_CHECKER: pat = (h[4] ^ v[4]) ? 8'hFF : 8'h00;
      default:      pat = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h         <= '0;
      v         <= '0;
      line_base <= '0;
    end else if (pix_ce) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v         <= '0;
          line_base <= '0;
        end else begin
          v <= v_inc;
          if ((v_inc < V_ACT) && ((v_inc & V_SC_MASK) == '0)) line_base <= line_base + WPL;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mode    <= MODE_FB;
      pending     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_hit;
      if (frame_hit) cur_mode <= mode_e'(pending);
      if (btn_next && !btn_prev)      pending <= pending + 2'd1;
      else if (btn_prev && !btn_next) pending <= pending - 2'd1;
    end
  end

  // Read data arrives on the edge after the strobe; it is used directly on that edge
  // and parked in word for the remaining pixels of the word (and for sparse pix_ce).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      word     <= '0;
    end else begin
      mem_rd <= fetch;
      if (fetch)  mem_addr <= word_addr;
      if (mem_rd) word     <= mem_data;
    end
  end

  assign src     = mem_rd ? mem_data : word;
  assign shifted = src << {sel1, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1   <= 1'b0;
      hs1   <= ~SYNC_ON;
      vs1   <= ~SYNC_ON;
      fb1   <= 1'b0;
      sel1  <= '0;
      pat1  <= '0;
      de    <= 1'b0;
      hsync <= ~SYNC_ON;
      vsync <= ~SYNC_ON;
      rgb   <= '0;
    end else if (pix_ce) begin
      de1   <= active;
      hs1   <= ((h >= HS_BEG) && (h < HS_END)) ? SYNC_ON : ~SYNC_ON;
      vs1   <= ((v >= VS_BEG) && (v < VS_END)) ? SYNC_ON : ~SYNC_ON;
      fb1   <= (mode_now == MODE_FB);
      sel1  <= sx & PX_MASK;
      pat1  <= pat;
      de    <= de1;
      hsync <= hs1;
      vsync <= vs1;
      rgb   <= de1 ? (fb1 ? shifted[DATA_W-1 -: 8] : pat1) : '0;
    end
  end

endmodule

// File: tb/tb_vga_frame_engine.sv
// Bench for vga_frame_engine with reduced timing: every clk is compared against a
// position/arithmetic reference model fed by random pixel enables and button presses.
module tb_vga_frame_engine;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
  localparam int SP = 0, SL = 1, PL = 1, DW = 16, AW = 7;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int SC = 1 << SL;
  localparam int NP = 1 << PL;
  localparam int WPL = HA / SC / NP;
  localparam logic SYNC_ON = (SP != 0);

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } px_t;

  logic clk = 1'b0;
  logic rst_n, pix_ce, btn_next, btn_prev;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic mem_rd, hsync, vsync, de, frame_start;
  logic [7:0] rgb;
  logic [1:0] mode;

  always #5 clk = ~clk;

  // RAM holds word n = {n[7:0], ~n[7:0]}; data is presented while the strobe is high.
  logic [7:0] a8;
  assign a8 = 8'(mem_addr);
  assign mem_data = mem_rd ? {a8, ~a8} : 16'hA55A;

  vga_frame_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP), .SCALE_LOG2(SL), .PIX_LOG2(PL), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .btn_next(btn_next), .btn_prev(btn_prev),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd), .hsync(hsync),
    .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start), .mode(mode)
  );

  int n_cmp = 0, n_bad = 0, rd_count = 0;
  int mh, mv;
  logic [1:0] pending, applied;
  px_t q[$];
  px_t exp_px;
  logic exp_rd, exp_fs;
  logic [AW-1:0] exp_addr;

  function automatic px_t idle_px();
    px_t p;
    p.de = 1'b0; p.hs = ~SYNC_ON; p.vs = ~SYNC_ON; p.rgb = 8'h00;
    return p;
  endfunction

  function automatic logic [7:0] bar_rgb(input int b);
    case (b)
      0: return 8'hFF;  1: return 8'hFC;  2: return 8'h1F;  3: return 8'h1C;
      4: return 8'hE3;  5: return 8'hE0;  6: return 8'h03;  default: return 8'h00;
    endcase
  endfunction

  function automatic int word_index(input int h, input int v);
    return ((v / SC) * WPL + (h / SC) / NP) % (1 << AW);
  endfunction

  function automatic px_t ref_pixel(input int h, input int v, input logic [1:0] m);
    px_t p;
    logic [7:0] a;
    logic [15:0] w;
    p.de  = (h < HA) && (v < VA);
    p.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? SYNC_ON : ~SYNC_ON;
    p.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? SYNC_ON : ~SYNC_ON;
    p.rgb = 8'h00;
    if (p.de) begin
      case (m)
        2'd0: begin
          a = 8'(word_index(h, v));
          w = {a, ~a};
          p.rgb = 8'(w >> (8 * (NP - 1 - (h / SC) % NP)));
        end
        2'd1: p.rgb = bar_rgb(h * 8 / HA);
        2'd2: p.rgb = (((h / 16) % 2) != ((v / 16) % 2)) ? 8'hFF : 8'h00;
        default: p.rgb = 8'h00;
      endcase
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  task automatic check_all();
    check("de", 32'(de), 32'(exp_px.de));
    check("hsync", 32'(hsync), 32'(exp_px.hs));
    check("vsync", 32'(vsync), 32'(exp_px.vs));
    check("rgb", 32'(rgb), 32'(exp_px.rgb));
    check("mem_rd", 32'(mem_rd), 32'(exp_rd));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("mode", 32'(mode), 32'(applied));
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; pending = '0; applied = '0;
    q.delete();
    q.push_back(idle_px());
    exp_px = idle_px(); exp_rd = 1'b0; exp_fs = 1'b0; exp_addr = '0;
  endtask

  task automatic step(input logic ce, input logic bn, input logic bp);
    px_t p;
    pix_ce = ce; btn_next = bn; btn_prev = bp;
    @(posedge clk);
    exp_fs = 1'b0;
    exp_rd = 1'b0;
    if (ce) begin
      if (mh == 0 && mv == 0) begin
        applied = pending;
        exp_fs  = 1'b1;
      end
      p = ref_pixel(mh, mv, applied);
      if (applied == 2'd0 && p.de && ((mh / SC) % NP) == 0 && (mh % SC) == 0) begin
        exp_rd   = 1'b1;
        exp_addr = AW'(word_index(mh, mv));
      end
      q.push_back(p);
      exp_px = q.pop_front();
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) mv = 0;
      end
    end
    if (bn && !bp) pending++;
    else if (bp && !bn) pending--;
    #1;
    check_all();
    if (mem_rd) rd_count++;
  endtask

  task automatic do_reset(input int clocks);
    btn_next = 1'b0; btn_prev = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (clocks) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic run_to_frame_start();
    for (int i = 0; i < HT * VT; i++) begin
      if (mh == 0 && mv == 0) break;
      step(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b1; pix_ce = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    model_reset();
    #2;
    do_reset(3);

    // One full frame in framebuffer mode: exact read count.
    rd_count = 0;
    for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0, 1'b0);
    check("reads_per_frame", 32'(rd_count), 32'(VA * HA / (SC * NP)));

    // Mid-frame next press: applies only at the following frame start.
    for (int i = 0; i < int'($urandom_range(HT * 5, HT * 20)); i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < HT * VT + 100; i++) step(1'b1, 1'b0, 1'b0);

    // Random presses, occasionally both at once.
    for (int i = 0; i < 3 * HT * VT; i++)
      step(1'b1, ($urandom_range(0, 299) == 0), ($urandom_range(0, 299) == 0));

    // Pixel enable 1 clk in 4, then random enable.
    for (int i = 0; i < 4 * HT * VT; i++)
      step((i % 4) == 0, ($urandom_range(0, 999) == 0), ($urandom_range(0, 999) == 0));
    for (int i = 0; i < HT * VT + 300; i++)
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 999) == 0), 1'b0);

    // Mid-frame reset, then scan restarts from pixel 0.
    for (int i = 0; i < int'($urandom_range(HT * 3, HT * 20)); i++) step(1'b1, 1'b0, 1'b0);
    pix_ce = 1'b1;
    do_reset(3);
    for (int i = 0; i < HT * VT + 50; i++) step(1'b1, 1'b0, 1'b0);

    // Prev from mode 0 wraps to 3: no reads during that frame.
    step(1'b1, 1'b0, 1'b1);
    run_to_frame_start();
    rd_count = 0;
    for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0, 1'b0);
    check("mode3_reads", 32'(rd_count), 32'd0);
    check("mode3_mode", 32'(mode), 32'd3);

    // Prev again: checkerboard frame.
    step(1'b1, 1'b0, 1'b1);
    run_to_frame_start();
    for (int i = 0; i < HT * VT + 10; i++) step(1'b1, 1'b0, 1'b0);
    check("mode2_mode", 32'(mode), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
